water_release_scheduler: RTL and testbench
==========================================

// Module: water_release_scheduler
// PURPOSE
//  Controller in front of the water management reservoir: shares reservoir outflow between the city and town
//  consumers and commands the rain/refill pump. Tracks reservoir_level with hysteresis to choose a supply
//  mode (NORMAL/RATION/DROUGHT), round-robin arbitrates city/town release requests into fixed-length bursts,
//  and sizes each burst from the requester's population.
// PARAMETERS
//  LEVEL_W    10   reservoir level width
//  POP_W      8    population width
//  LOW_TH     300  level below which RATION is entered
//  CRIT_TH    100  level below which DROUGHT is entered
//  HYST       50   hysteresis margin added to a threshold before returning to the higher mode
//  BURST_LEN  4    grant duration in cycles (>=1)
// PORTS
//  clk              in   1        single clock, rising edge
//  reset            in   1        asynchronous, active-high; clears all state immediately
//  reservoir_level  in   LEVEL_W  current reservoir level
//  underflow        in   1        reservoir underflow flag; aborts an active burst
//  city_population  in   POP_W    city population, sampled at grant start
//  town_population  in   POP_W    town population, sampled at grant start
//  city_req         in   1        level request for a release burst
//  town_req         in   1        level request for a release burst
//  city_grant       out  1        city burst active
//  town_grant       out  1        town burst active; never high together with city_grant
//  release_amt      out  LEVEL_W  amount released this burst; 0 when no grant
//  pump_on          out  1        refill pump command
//  mode             out  2        00 NORMAL, 01 RATION, 10 DROUGHT
//  denied           out  1        1-cycle pulse: selected request refused
// BEHAVIOUR
//  Reset: mode=NORMAL, arb=IDLE, grants=0, release_amt=0, pump_on=0, denied=0, rr pointer=TOWN (city first).
//  Mode FSM, evaluated every cycle on registered level compare, one transition per cycle:
//   NORMAL->DROUGHT level<CRIT_TH; else NORMAL->RATION level<LOW_TH.
//   RATION->DROUGHT level<CRIT_TH; RATION->NORMAL level>=LOW_TH+HYST.
//   DROUGHT->RATION level>=CRIT_TH+HYST only (never straight to NORMAL).
//  pump_on = registered (mode!=NORMAL); updates in the same edge as mode.
//  Arbiter FSM IDLE -> GRANT -> GAP -> IDLE:
//   IDLE: if any req, select: the only requester, or the one not last served if both. Eligibility:
//    mode!=DROUGHT and amt<=reservoir_level, amt = {0,pop} in NORMAL, {0,pop>>1} in RATION.
//    Eligible: next edge assert that grant, latch release_amt=amt, rr pointer=selected, go GRANT.
//    Ineligible: denied pulses next cycle, rr pointer=selected (other side gets priority), stay IDLE.
//   GRANT: hold grant and release_amt for BURST_LEN cycles; mode change mid-burst does not alter the burst.
//    underflow=1 during GRANT: grant and release_amt drop on next edge, go GAP (abort, no denied).
//   GAP: exactly 1 cycle, grants=0, release_amt=0; requests ignored.
//  Latency: req high in IDLE at edge N -> grant high after edge N+1; back-to-back bursts separated by >=1 GAP cycle.
//  Request deasserted during GRANT does not shorten the burst.
//  Widths: amt zero-extended POP_W->LEVEL_W; compare unsigned; no arithmetic wrap possible (POP_W<LEVEL_W).
//  Reset asserted mid-burst: outputs go to reset values asynchronously; rr pointer restored to TOWN.
// STRUCTURE
//  Package wms_pkg: mode encodings (MODE_NORMAL/RATION/DROUGHT), arbiter state enum (ARB_IDLE/GRANT/GAP),
//   default threshold constants shared with water_management_system.
//  Sub-module wms_level_mode: hysteresis mode FSM + pump_on; top holds the arbiter, burst counter, rr pointer.
// TESTING
//  1 Reset with level=500, city_req=town_req=0 -> mode=00, pump_on=0, grants=0, release_amt=0.
//  2 level=500, city_pop=40, town_pop=30, both req held -> city grant 4 cycles amt=40, 1 gap, town 4 cycles
//    amt=30, gap, city again (strict alternation).
//  3 level 500->250, city_pop=40, city_req -> mode=01, pump_on=1, city grant amt=20; level 320 stays RATION,
//    level 350 -> NORMAL, pump_on=0.
//  4 level=80, town_req -> mode=10, denied pulse, no grant; level 140 stays DROUGHT, 150 -> RATION only.
//  5 level=500, city_pop=200, level then 150 (RATION): amt=100 granted; city_pop=250 with level=100 NORMAL-
//    hysteresis case forced -> amt>level -> denied, then town (pop 30) granted next IDLE evaluation.
//  6 underflow=1 in 2nd grant cycle -> grant/release_amt 0 next edge, GAP, IDLE; reset mid-burst -> immediate clear.

Source files
------------

// File: rtl/wms_pkg.sv
// Shared types and default constants for the water management reservoir controllers.
package wms_pkg;

  localparam int LEVEL_W_DEF   = 10;
  localparam int POP_W_DEF     = 8;
  localparam int LOW_TH_DEF    = 300;
  localparam int CRIT_TH_DEF   = 100;
  localparam int HYST_DEF      = 50;
  localparam int BURST_LEN_DEF = 4;

  typedef enum logic [1:0] {
    MODE_NORMAL  = 2'b00,
    MODE_RATION  = 2'b01,
    MODE_DROUGHT = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_GRANT = 2'b01,
    ARB_GAP   = 2'b10
  } arb_state_t;

  typedef enum logic {
    SIDE_CITY = 1'b0,
    SIDE_TOWN = 1'b1
  } side_t;

endpackage

// File: rtl/wms_level_mode.sv
// Hysteresis supply-mode FSM driven by registered threshold compares of the reservoir level.
module wms_level_mode
  import wms_pkg::*;
#(
  parameter int LEVEL_W = LEVEL_W_DEF,
  parameter int LOW_TH  = LOW_TH_DEF,
  parameter int CRIT_TH = CRIT_TH_DEF,
  parameter int HYST    = HYST_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] reservoir_level,
  output mode_t              mode,
  output logic               pump_on
);

  logic  below_crit;
  logic  below_low;
  logic  above_low_hyst;
  logic  above_crit_hyst;
  mode_t mode_next;

  // Reset values describe a full reservoir so the FSM rests in NORMAL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      below_crit      <= 1'b0;
      below_low       <= 1'b0;
      above_low_hyst  <= 1'b1;
      above_crit_hyst <= 1'b1;
    end else begin
      below_crit      <= reservoir_level <  LEVEL_W'(CRIT_TH);
      below_low       <= reservoir_level <  LEVEL_W'(LOW_TH);
      above_low_hyst  <= reservoir_level >= LEVEL_W'(LOW_TH + HYST);
      above_crit_hyst <= reservoir_level >= LEVEL_W'(CRIT_TH + HYST);
    end
  end

  always_comb begin
    mode_next = mode;
    case (mode)
      MODE_NORMAL: begin
        if (below_crit)     mode_next = MODE_DROUGHT;
        else if (below_low) mode_next = MODE_RATION;
      end
      MODE_RATION: begin
        if (below_crit)          mode_next = MODE_DROUGHT;
        else if (above_low_hyst) mode_next = MODE_NORMAL;
      end
      MODE_DROUGHT: begin
        if (above_crit_hyst) mode_next = MODE_RATION;
      end
      default: mode_next = MODE_NORMAL;
    endcase
  end

  // pump_on follows the mode being entered so both change on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode    <= MODE_NORMAL;
      pump_on <= 1'b0;
    end else begin
      mode    <= mode_next;
      pump_on <= (mode_next != MODE_NORMAL);
    end
  end

endmodule

// File: rtl/water_release_scheduler.sv
// Round-robin city/town release arbiter with population-sized bursts, gated by the supply mode.
module water_release_scheduler
  import wms_pkg::*;
#(
  parameter int LEVEL_W   = LEVEL_W_DEF,
  parameter int POP_W     = POP_W_DEF,
  parameter int LOW_TH    = LOW_TH_DEF,
  parameter int CRIT_TH   = CRIT_TH_DEF,
  parameter int HYST      = HYST_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] reservoir_level,
  input  logic               underflow,
  input  logic [POP_W-1:0]   city_population,
  input  logic [POP_W-1:0]   town_population,
  input  logic               city_req,
  input  logic               town_req,
  output logic               city_grant,
  output logic               town_grant,
  output logic [LEVEL_W-1:0] release_amt,
  output logic               pump_on,
  output logic [1:0]         mode,
  output logic               denied
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  mode_t              cur_mode;
  arb_state_t         state;
  side_t              last_served;
  logic [CNT_W-1:0]   burst_cnt;
  logic               pick_town;
  logic [POP_W-1:0]   sel_pop;
  logic [LEVEL_W-1:0] amt;
  logic               eligible;

  wms_level_mode #(
    .LEVEL_W (LEVEL_W),
    .LOW_TH  (LOW_TH),
    .CRIT_TH (CRIT_TH),
    .HYST    (HYST)
  ) u_level_mode (
    .clk             (clk),
    .reset           (reset),
    .reservoir_level (reservoir_level),
    .mode            (cur_mode),
    .pump_on         (pump_on)
  );

  assign mode = cur_mode;

  // Town wins when it is the only requester or when city was served last.
  always_comb begin
    pick_town = town_req && (!city_req || (last_served == SIDE_CITY));
    sel_pop   = pick_town ? town_population : city_population;
    amt       = LEVEL_W'(sel_pop);
    if (cur_mode == MODE_RATION) amt = LEVEL_W'(sel_pop >> 1);
    eligible  = (cur_mode != MODE_DROUGHT) && (amt <= reservoir_level);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ARB_IDLE;
      city_grant  <= 1'b0;
      town_grant  <= 1'b0;
      release_amt <= '0;
      denied      <= 1'b0;
      last_served <= SIDE_TOWN;
      burst_cnt   <= '0;
    end else begin
      denied <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (city_req || town_req) begin
            last_served <= pick_town ? SIDE_TOWN : SIDE_CITY;
            if (eligible) begin
              city_grant  <= !pick_town;
              town_grant  <= pick_town;
              release_amt <= amt;
              burst_cnt   <= '0;
              state       <= ARB_GRANT;
            end else begin
              denied <= 1'b1;
            end
          end
        end
        ARB_GRANT: begin
          // Underflow aborts early; otherwise the burst runs its full length.
          if (underflow || (burst_cnt == CNT_W'(BURST_LEN - 1))) begin
            city_grant  <= 1'b0;
            town_grant  <= 1'b0;
            release_amt <= '0;
            state       <= ARB_GAP;
          end else begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        ARB_GAP: state <= ARB_IDLE;
        default: begin
          city_grant  <= 1'b0;
          town_grant  <= 1'b0;
          release_amt <= '0;
          state       <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_water_release_scheduler.sv
// Directed, table-driven bench for water_release_scheduler plus reset corner sequences.
module tb_water_release_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] reservoir_level;
  logic       underflow;
  logic [7:0] city_population;
  logic [7:0] town_population;
  logic       city_req;
  logic       town_req;
  logic       city_grant;
  logic       town_grant;
  logic [9:0] release_amt;
  logic       pump_on;
  logic [1:0] mode;
  logic       denied;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int lvl;
    int cpop;
    int tpop;
    bit creq;
    bit treq;
    bit uf;
    bit ecg;
    bit etg;
    int eamt;
    int emode;
    bit epump;
    bit eden;
  } vec_t;

  vec_t vq[$];

  water_release_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .reservoir_level (reservoir_level),
    .underflow       (underflow),
    .city_population (city_population),
    .town_population (town_population),
    .city_req        (city_req),
    .town_req        (town_req),
    .city_grant      (city_grant),
    .town_grant      (town_grant),
    .release_amt     (release_amt),
    .pump_on         (pump_on),
    .mode            (mode),
    .denied          (denied)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int lvl, int cpop, int tpop, bit creq, bit treq, bit uf,
                              bit ecg, bit etg, int eamt, int emode, bit epump, bit eden);
    vec_t v;
    v.lvl = lvl; v.cpop = cpop; v.tpop = tpop;
    v.creq = creq; v.treq = treq; v.uf = uf;
    v.ecg = ecg; v.etg = etg; v.eamt = eamt;
    v.emode = emode; v.epump = epump; v.eden = eden;
    return v;
  endfunction

  task automatic add(vec_t v, int n);
    for (int k = 0; k < n; k++) vq.push_back(v);
  endtask

  task automatic applyStimulus(vec_t v);
    reservoir_level = 10'(v.lvl);
    city_population = 8'(v.cpop);
    town_population = 8'(v.tpop);
    city_req        = v.creq;
    town_req        = v.treq;
    underflow       = v.uf;
  endtask

  task automatic checkOutput(int idx, vec_t v);
    checks++;
    if (city_grant !== v.ecg || town_grant !== v.etg || release_amt !== 10'(v.eamt) ||
        mode !== 2'(v.emode) || pump_on !== v.epump || denied !== v.eden) begin
      errors++;
      $display("[TB] FAIL vec%0d: got cg=%0b tg=%0b amt=%0d mode=%0d pump=%0b den=%0b, expected cg=%0b tg=%0b amt=%0d mode=%0d pump=%0b den=%0b",
               idx, city_grant, town_grant, release_amt, mode, pump_on, denied,
               v.ecg, v.etg, v.eamt, v.emode, v.epump, v.eden);
    end
  endtask

  task automatic checkVal(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    // Alternating bursts with both requesters held: city first after reset
    add(mk(500, 40, 30, 1, 1, 0, 1, 0, 40, 0, 0, 0), 4);
    add(mk(500, 40, 30, 1, 1, 0, 0, 0, 0, 0, 0, 0), 2);
    add(mk(500, 40, 30, 1, 1, 0, 0, 1, 30, 0, 0, 0), 4);
    add(mk(500, 40, 30, 1, 1, 0, 0, 0, 0, 0, 0, 0), 2);
    add(mk(500, 40, 30, 1, 1, 0, 1, 0, 40, 0, 0, 0), 1);
    add(mk(500, 40, 30, 0, 0, 0, 1, 0, 40, 0, 0, 0), 3);
    // Drop into RATION, half-sized burst, then hysteresis back to NORMAL
    add(mk(250, 40, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    add(mk(250, 40, 30, 0, 0, 0, 0, 0, 0, 1, 1, 0), 1);
    add(mk(250, 40, 30, 1, 0, 0, 1, 0, 20, 1, 1, 0), 1);
    add(mk(250, 40, 30, 0, 0, 0, 1, 0, 20, 1, 1, 0), 3);
    add(mk(320, 40, 30, 0, 0, 0, 0, 0, 0, 1, 1, 0), 2);
    add(mk(350, 40, 30, 0, 0, 0, 0, 0, 0, 1, 1, 0), 1);
    add(mk(350, 40, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    // DROUGHT refuses the request; recovery only reaches RATION
    add(mk(80, 40, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    add(mk(80, 40, 30, 0, 0, 0, 0, 0, 0, 2, 1, 0), 1);
    add(mk(80, 40, 30, 0, 1, 0, 0, 0, 0, 2, 1, 1), 1);
    add(mk(80, 40, 30, 0, 0, 0, 0, 0, 0, 2, 1, 0), 1);
    add(mk(140, 40, 30, 0, 0, 0, 0, 0, 0, 2, 1, 0), 2);
    add(mk(150, 40, 30, 0, 0, 0, 0, 0, 0, 2, 1, 0), 1);
    add(mk(150, 40, 30, 0, 0, 0, 0, 0, 0, 1, 1, 0), 2);
    // RATION burst of 100, then an oversized request is denied and town goes next
    add(mk(150, 200, 30, 1, 0, 0, 1, 0, 100, 1, 1, 0), 1);
    add(mk(150, 200, 30, 0, 0, 0, 1, 0, 100, 1, 1, 0), 3);
    add(mk(110, 250, 30, 0, 0, 0, 0, 0, 0, 1, 1, 0), 2);
    add(mk(110, 250, 30, 1, 0, 0, 0, 0, 0, 1, 1, 1), 1);
    add(mk(110, 250, 30, 1, 1, 0, 0, 1, 15, 1, 1, 0), 1);
    add(mk(110, 250, 30, 0, 0, 0, 0, 1, 15, 1, 1, 0), 3);
    // Back to NORMAL, underflow aborts the burst in its second cycle
    add(mk(500, 250, 30, 0, 0, 0, 0, 0, 0, 1, 1, 0), 1);
    add(mk(500, 250, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    add(mk(500, 250, 30, 1, 0, 0, 1, 0, 250, 0, 0, 0), 1);
    add(mk(500, 250, 30, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1);
    add(mk(500, 250, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    add(mk(500, 250, 30, 1, 0, 0, 1, 0, 250, 0, 0, 0), 1);

    reset = 1'b1;
    applyStimulus(mk(500, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    checkVal("reset_mode", int'(mode), 0);
    checkVal("reset_pump", int'(pump_on), 0);
    checkVal("reset_city_grant", int'(city_grant), 0);
    checkVal("reset_town_grant", int'(town_grant), 0);
    checkVal("reset_amt", int'(release_amt), 0);
    checkVal("reset_denied", int'(denied), 0);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      applyStimulus(vq[i]);
      @(negedge clk);
      checkOutput(i, vq[i]);
    end

    // City burst is active here; reset between edges must clear it at once
    applyStimulus(mk(500, 40, 30, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    #2 reset = 1'b1;
    #1;
    checkVal("async_reset_city_grant", int'(city_grant), 0);
    checkVal("async_reset_amt", int'(release_amt), 0);
    checkVal("async_reset_mode", int'(mode), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkVal("post_reset_city_first", int'(city_grant), 1);
    checkVal("post_reset_town_idle", int'(town_grant), 0);
    checkVal("post_reset_amt", int'(release_amt), 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
